// File: rtl/hazard_fwd_ctrl.sv
// Load-use hazard detection and EX-stage forwarding select generation for a 5-stage MIPS pipeline.
// Forward selects are resolved in ID and registered so they line up with the consumer's EX cycle.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelMemWb   = 2'b01;
  localparam logic [1:0] SelExMem   = 2'b10;

  // ID/EX record
  logic              idex_valid_q, idex_valid_d;
  logic              idex_regwrite_q, idex_regwrite_d;
  logic              idex_memread_q, idex_memread_d;
  logic [REG_AW-1:0] idex_dest_q, idex_dest_d;

  // EX/MEM record; only the write intent and destination feed forwarding. By the time the
  // consumer reaches EX this producer sits in MEM/WB, so no separate MEM/WB record is needed.
  logic              exmem_wr_q, exmem_wr_d;
  logic [REG_AW-1:0] exmem_dest_q, exmem_dest_d;

  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic stall;
  logic bubble;
  logic idex_fwd_ok;

  function automatic logic [1:0] fwd_sel(input logic              uses,
                                         input logic [REG_AW-1:0] src,
                                         input logic              idex_ok,
                                         input logic [REG_AW-1:0] idex_dest,
                                         input logic              exmem_wr,
                                         input logic [REG_AW-1:0] exmem_dest);
    logic [1:0] sel;
    sel = SelRegFile;
    if (uses) begin
      if (idex_ok && idex_dest == src) begin
        sel = SelExMem;
      end else if (exmem_wr && exmem_dest != '0 && exmem_dest == src) begin
        sel = SelMemWb;
      end
    end
    return sel;
  endfunction

  always_comb begin
    stall = id_valid_i & idex_valid_q & idex_memread_q & (idex_dest_q != '0) &
            ((id_uses_rs_i & (id_rs_i == idex_dest_q)) |
             (id_uses_rt_i & (id_rt_i == idex_dest_q)));
    bubble      = stall | flush_i | ~id_valid_i;
    idex_fwd_ok = idex_valid_q & idex_regwrite_q & (idex_dest_q != '0);

    idex_valid_d    = ~bubble;
    idex_regwrite_d = id_regwrite_i;
    idex_memread_d  = id_memread_i;
    idex_dest_d     = id_dest_i;

    exmem_wr_d   = idex_valid_q & idex_regwrite_q;
    exmem_dest_d = idex_dest_q;

    fwd_a_d = SelRegFile;
    fwd_b_d = SelRegFile;
    if (!bubble) begin
      fwd_a_d = fwd_sel(id_uses_rs_i, id_rs_i, idex_fwd_ok, idex_dest_q, exmem_wr_q, exmem_dest_q);
      fwd_b_d = fwd_sel(id_uses_rt_i, id_rt_i, idex_fwd_ok, idex_dest_q, exmem_wr_q, exmem_dest_q);
    end

    cnt_d = cnt_q;
    if (stall && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_q    <= 1'b0;
      idex_regwrite_q <= 1'b0;
      idex_memread_q  <= 1'b0;
      idex_dest_q     <= '0;
      exmem_wr_q      <= 1'b0;
      exmem_dest_q    <= '0;
      fwd_a_q         <= SelRegFile;
      fwd_b_q         <= SelRegFile;
      cnt_q           <= '0;
    end else begin
      idex_valid_q    <= idex_valid_d;
      idex_regwrite_q <= idex_regwrite_d;
      idex_memread_q  <= idex_memread_d;
      idex_dest_q     <= idex_dest_d;
      exmem_wr_q      <= exmem_wr_d;
      exmem_dest_q    <= exmem_dest_d;
      fwd_a_q         <= fwd_a_d;
      fwd_b_q         <= fwd_b_d;
      cnt_q           <= cnt_d;
    end
  end

  assign stall_o       = stall;
  assign fwd_a_sel_o   = fwd_a_q;
  assign fwd_b_sel_o   = fwd_b_q;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use stall, $0, flush, reset, saturation.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
  logic       flush = 1'b0;

  logic        stall, stall2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .id_dest_i(id_dest), .flush_i(flush), .stall_o(stall),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b), .stall_count_o(cnt)
  );

  hazard_fwd_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .id_dest_i(id_dest), .flush_i(flush), .stall_o(stall2),
    .fwd_a_sel_o(fwd_a2), .fwd_b_sel_o(fwd_b2), .stall_count_o(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID: rs/rt use flags, regwrite, memread, destination.
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw, input logic mr,
                        input logic [4:0] dest);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_regwrite = rw; id_memread = mr; id_dest = dest;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    nop();
    #12;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("reset_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("reset_cnt", {16'd0, cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: add $3,$1,$2 ; sub $4,$3,$5
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    tick();
    set_id(1, 5'd3, 5'd5, 1, 1, 1, 0, 5'd4);
    chk("t1_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t1_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("t1_fwd_b", {30'd0, fwd_b}, 32'd0);

    // 2: add $3 ; nop ; or $6,$7,$3
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    tick();
    nop();
    tick();
    set_id(1, 5'd7, 5'd3, 1, 1, 1, 0, 5'd6);
    tick();
    chk("t2_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("t2_fwd_b", {30'd0, fwd_b}, 32'd1);

    // 3: lw $8,0($9) ; add $10,$8,$8
    set_id(1, 5'd9, 5'd0, 1, 0, 1, 1, 5'd8);
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 1, 0, 5'd10);
    chk("t3_stall_hi", {31'd0, stall}, 32'd1);
    tick();
    chk("t3_bubble_a", {30'd0, fwd_a}, 32'd0);
    chk("t3_bubble_b", {30'd0, fwd_b}, 32'd0);
    chk("t3_stall_lo", {31'd0, stall}, 32'd0);
    chk("t3_cnt", {16'd0, cnt}, 32'd1);
    tick();
    chk("t3_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("t3_fwd_b", {30'd0, fwd_b}, 32'd1);
    chk("t3_cnt_hold", {16'd0, cnt}, 32'd1);

    // 4: add $0 ; lw $0 ; consumer reads $0
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd0);
    tick();
    set_id(1, 5'd9, 5'd0, 1, 0, 1, 1, 5'd0);
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd11);
    chk("t4_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t4_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("t4_fwd_b", {30'd0, fwd_b}, 32'd0);

    // 5: add $3 ; sub $3 ; consumer of $3 -> newer wins; then flush
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    tick();
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    tick();
    set_id(1, 5'd3, 5'd3, 1, 1, 1, 0, 5'd7);
    tick();
    chk("t5_newer_a", {30'd0, fwd_a}, 32'd2);
    chk("t5_newer_b", {30'd0, fwd_b}, 32'd2);
    flush = 1'b1;
    set_id(1, 5'd3, 5'd3, 1, 1, 1, 0, 5'd9);
    tick();
    flush = 1'b0;
    chk("t5_flush_a", {30'd0, fwd_a}, 32'd0);
    chk("t5_flush_b", {30'd0, fwd_b}, 32'd0);
    set_id(1, 5'd9, 5'd0, 1, 0, 1, 0, 5'd12);
    tick();
    chk("t5_flushed_rec", {30'd0, fwd_a}, 32'd0);

    // 6: async reset mid-sequence
    set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    tick();
    set_id(1, 5'd3, 5'd0, 1, 0, 1, 1, 5'd5);
    tick();
    chk("t6_pre_fwd_a", {30'd0, fwd_a}, 32'd2);
    set_id(1, 5'd5, 5'd0, 1, 0, 1, 0, 5'd6);
    chk("t6_pre_stall", {31'd0, stall}, 32'd1);
    chk("t6_pre_cnt", {16'd0, cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("t6_rst_cnt", {16'd0, cnt}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_no_stale_a", {30'd0, fwd_a}, 32'd0);
    chk("t6_post_cnt", {16'd0, cnt}, 32'd0);

    // Five load-use stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_id(1, 5'd9, 5'd0, 1, 0, 1, 1, 5'd8);
      tick();
      set_id(1, 5'd8, 5'd8, 1, 1, 1, 0, 5'd10);
      chk("sat_stall", {31'd0, stall2}, 32'd1);
      tick();
      tick();
      chk("sat_cnt16", {16'd0, cnt}, i + 1);
      chk("sat_cnt2", {30'd0, cnt2}, (i + 1 > 3) ? 3 : i + 1);
    end
    chk("sat_fwd2", {28'd0, fwd_a2, fwd_b2}, 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
